// File: rtl/aes_ctrl_pkg.sv
// Shared types and defaults for the AES core arbiter.
//   arb_state_t : arbiter FSM states
//   *_DEF       : default parameter values
//   idx_width() : index/counter width helper (never returns 0)
package aes_ctrl_pkg;

    localparam int N_REQ_DEF       = 4;
    localparam int DATA_W_DEF      = 128;
    localparam int KEY_L_DEF       = 128;
    localparam int TIMEOUT_CYC_DEF = 64;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

    // Width needed to hold values 0..n-1; at least 1 bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aes_core_arbiter_if.sv
// Requester-side bus of the AES core arbiter.
//   req_valid/req_ready/req_key/req_text : per-requester request channel
//   rsp_valid/rsp_ready/rsp_text/rsp_err : per-requester response channel
// master = requesters, slave = arbiter.
interface aes_core_arbiter_if
    import aes_ctrl_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int KEY_L  = KEY_L_DEF
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*KEY_L-1:0]  req_key;
    logic [N_REQ*DATA_W-1:0] req_text;
    logic [N_REQ-1:0]        rsp_valid;
    logic [N_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]       rsp_text;
    logic                    rsp_err;

    modport master (
        output req_valid, req_key, req_text, rsp_ready,
        input  req_ready, rsp_valid, rsp_text, rsp_err
    );

    modport slave (
        input  req_valid, req_key, req_text, rsp_ready,
        output req_ready, rsp_valid, rsp_text, rsp_err
    );
endinterface

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin picker.
//   req_valid : request vector
//   ptr       : highest-priority index for this pick
//   grant     : one-hot winner (zero when nothing is valid)
//   grant_idx : binary index of the winner (0 when nothing is valid)
module aes_rr_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    localparam int OWN_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [OWN_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [OWN_W-1:0] grant_idx
);
    logic             found;
    logic [OWN_W-1:0] cand;

    always_comb begin
        // NOTE: every variable assigned here gets a default first so no path leaves one unassigned (no latch).
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        // Scan ptr, ptr+1, ... with wrap; the first valid requester wins.
        for (int i = 0; i < N_REQ; i++) begin
            cand = OWN_W'((int'(ptr) + i) % N_REQ);
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        if (found) grant = N_REQ'(1) << grant_idx;
    end
endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES-128 core among N_REQ requesters, one block in flight.
//   clk, reset       : clock, synchronous active-high reset
//   bus              : requester request/response channels (slave side)
//   core_valid_in    : one-cycle start strobe to the core
//   core_cipher_key  : registered key, stable from ISSUE until back in IDLE
//   core_plain_text  : registered plaintext, same stability
//   core_cipher_text : core result
//   core_valid_out   : core result valid
//   busy             : FSM not in IDLE
//   stray_out        : sticky, core result seen outside WAIT
module aes_core_arbiter
    import aes_ctrl_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int KEY_L       = KEY_L_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    aes_core_arbiter_if.slave bus,
    output logic              core_valid_in,
    output logic [KEY_L-1:0]  core_cipher_key,
    output logic [DATA_W-1:0] core_plain_text,
    input  logic [DATA_W-1:0] core_cipher_text,
    input  logic              core_valid_out,
    output logic              busy,
    output logic              stray_out
);
    localparam int OWN_W = idx_width(N_REQ);
    localparam int TMR_W = idx_width(TIMEOUT_CYC);

    arb_state_t        state_q, state_d;
    logic [OWN_W-1:0]  ptr_q, owner_q, grant_idx;
    logic [N_REQ-1:0]  grant;
    logic [KEY_L-1:0]  key_q;
    logic [DATA_W-1:0] text_q, result_q;
    logic              err_q, stray_q;
    logic [TMR_W-1:0]  timer_q;
    logic              req_fire, rsp_fire, timeout;

    aes_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req_valid (bus.req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Reset blocks grants so nothing is captured in a reset cycle.
    assign req_fire = (state_q == IDLE) && !reset && (|grant);
    assign rsp_fire = (state_q == RESP) && bus.rsp_ready[owner_q];
    assign timeout  = (timer_q == TMR_W'(TIMEOUT_CYC - 1));

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_fire) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (core_valid_out || timeout) state_d = RESP;
            RESP:    if (rsp_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        core_valid_in = 1'b0;
        case (state_q)
            IDLE:    if (!reset) bus.req_ready = grant;
            ISSUE:   core_valid_in = 1'b1;
            RESP:    bus.rsp_valid = N_REQ'(1) << owner_q;
            default: ;
        endcase
    end

    assign bus.rsp_text     = result_q;
    assign bus.rsp_err      = err_q;
    assign core_cipher_key  = key_q;
    assign core_plain_text  = text_q;
    assign busy             = (state_q != IDLE);
    assign stray_out        = stray_q;

    // Datapath: owner, operands, result, timer, rr pointer, stray flag
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the wide operand/result registers are reset too, because every output must read 0 after reset.
            ptr_q    <= '0;
            owner_q  <= '0;
            key_q    <= '0;
            text_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            timer_q  <= '0;
            stray_q  <= 1'b0;
        end else begin
            if (req_fire) begin
                owner_q <= grant_idx;
                key_q   <= KEY_L'(bus.req_key >> (int'(grant_idx) * KEY_L));
                text_q  <= DATA_W'(bus.req_text >> (int'(grant_idx) * DATA_W));
            end

            if (state_q == ISSUE)     timer_q <= '0;
            else if (state_q == WAIT) timer_q <= timer_q + 1'b1;

            // A result arriving on the timeout cycle takes precedence.
            if (state_q == WAIT) begin
                if (core_valid_out) begin
                    result_q <= core_cipher_text;
                    err_q    <= 1'b0;
                end else if (timeout) begin
                    result_q <= '0;
                    err_q    <= 1'b1;
                end
            end

            if (rsp_fire)
                ptr_q <= (owner_q == OWN_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

            // Results outside WAIT (e.g. late after a reset) are dropped and flagged.
            if (core_valid_out && state_q != WAIT) stray_q <= 1'b1;
        end
    end
endmodule
